// File: rtl/ram_bank_access_ctrl_if.sv
// Requester/bank bus of the banked RAM access controller.
// Port A (core), port B (loader/DMA) and the four 8-bit bank RAM lanes.
interface ram_bank_access_ctrl_if #(
    parameter int BYTE_ADDR_W = 18
);
    localparam int WW = BYTE_ADDR_W - 2;

    logic                   a_req;
    logic                   a_we;
    logic [1:0]             a_size;
    logic [BYTE_ADDR_W-1:0] a_addr;
    logic [31:0]            a_wdata;
    logic                   a_gnt;
    logic                   a_ack;
    logic [31:0]            a_rdata;

    logic                   b_req;
    logic                   b_we;
    logic [1:0]             b_size;
    logic [BYTE_ADDR_W-1:0] b_addr;
    logic [31:0]            b_wdata;
    logic                   b_gnt;
    logic                   b_ack;
    logic [31:0]            b_rdata;

    logic [WW-1:0]          ram_addr0;
    logic [WW-1:0]          ram_addr1;
    logic [WW-1:0]          ram_addr2;
    logic [WW-1:0]          ram_addr3;
    logic [7:0]             ram_wdata0;
    logic [7:0]             ram_wdata1;
    logic [7:0]             ram_wdata2;
    logic [7:0]             ram_wdata3;
    logic [3:0]             ram_we;
    logic [7:0]             ram_rdata0;
    logic [7:0]             ram_rdata1;
    logic [7:0]             ram_rdata2;
    logic [7:0]             ram_rdata3;
    logic                   busy;

    modport slave (
        input  a_req, a_we, a_size, a_addr, a_wdata,
        output a_gnt, a_ack, a_rdata,
        input  b_req, b_we, b_size, b_addr, b_wdata,
        output b_gnt, b_ack, b_rdata,
        output ram_addr0, ram_addr1, ram_addr2, ram_addr3,
        output ram_wdata0, ram_wdata1, ram_wdata2, ram_wdata3,
        output ram_we,
        input  ram_rdata0, ram_rdata1, ram_rdata2, ram_rdata3,
        output busy
    );

    modport master (
        output a_req, a_we, a_size, a_addr, a_wdata,
        input  a_gnt, a_ack, a_rdata,
        output b_req, b_we, b_size, b_addr, b_wdata,
        input  b_gnt, b_ack, b_rdata,
        input  ram_addr0, ram_addr1, ram_addr2, ram_addr3,
        input  ram_wdata0, ram_wdata1, ram_wdata2, ram_wdata3,
        input  ram_we,
        output ram_rdata0, ram_rdata1, ram_rdata2, ram_rdata3,
        input  busy
    );
endinterface

// File: rtl/ram_bank_access_ctrl.sv
// Round-robin sharing of a 4x8-bit banked RAM between two requesters, unaligned access support.
// Latency: gnt +1, write ack +2, read ack +2+RD_LATENCY; requests outside IDLE wait (req held).
module ram_bank_access_ctrl #(
    parameter int BYTE_ADDR_W = 18,
    parameter int RD_LATENCY  = 1
) (
    input logic clk,
    input logic rst_n,
    ram_bank_access_ctrl_if.slave bus
);
    localparam int WW = BYTE_ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t        state;
    logic          last_grant;      // 0 = A, 1 = B
    logic          sel;
    logic          lat_we;
    logic [1:0]    lat_off;
    logic [1:0]    cnt;
    logic [WW-1:0] addr_q  [4];
    logic [7:0]    wdata_q [4];
    logic [3:0]    we_q;
    logic          a_gnt_q, b_gnt_q, a_ack_q, b_ack_q;
    logic [31:0]   a_rdata_q, b_rdata_q;

    logic                   pick_b;
    logic                   any_req;
    logic                   s_we;
    logic [1:0]             s_size;
    logic [BYTE_ADDR_W-1:0] s_addr;
    logic [31:0]            s_wdata;
    logic [WW-1:0]          s_word;
    logic [1:0]             s_off;
    logic [2:0]             nbytes;
    logic [1:0]             rel     [4];
    logic [WW-1:0]          n_addr  [4];
    logic [7:0]             n_wdata [4];
    logic [3:0]             n_we;
    logic [7:0]             rd_bank [4];
    logic [31:0]            rd_rot;

    always_comb begin
        pick_b  = bus.b_req && (!bus.a_req || !last_grant);
        any_req = bus.a_req || bus.b_req;
        s_we    = pick_b ? bus.b_we    : bus.a_we;
        s_size  = pick_b ? bus.b_size  : bus.a_size;
        s_addr  = pick_b ? bus.b_addr  : bus.a_addr;
        s_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
        s_word  = s_addr[BYTE_ADDR_W-1:2];
        s_off   = s_addr[1:0];
        case (s_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        n_we = 4'b0000;
        // Bank j holds data byte (j - off) mod 4; banks below off belong to the next word.
        for (int j = 0; j < 4; j++) begin
            rel[j]     = 2'(j) - s_off;
            n_addr[j]  = s_word + WW'(2'(j) < s_off);
            n_wdata[j] = s_wdata[8*rel[j] +: 8];
            n_we[j]    = s_we && ({1'b0, rel[j]} < nbytes);
        end
    end

    assign rd_bank[0] = bus.ram_rdata0;
    assign rd_bank[1] = bus.ram_rdata1;
    assign rd_bank[2] = bus.ram_rdata2;
    assign rd_bank[3] = bus.ram_rdata3;

    always_comb begin
        rd_rot = '0;
        for (int k = 0; k < 4; k++) begin
            rd_rot[8*k +: 8] = rd_bank[lat_off + 2'(k)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            lat_we     <= 1'b0;
            lat_off    <= 2'd0;
            cnt        <= 2'd0;
            for (int j = 0; j < 4; j++) begin
                addr_q[j]  <= '0;
                wdata_q[j] <= '0;
            end
            we_q       <= 4'b0000;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel        <= pick_b;
                        last_grant <= pick_b;
                        lat_we     <= s_we;
                        lat_off    <= s_off;
                        addr_q     <= n_addr;
                        wdata_q    <= n_wdata;
                        we_q       <= n_we;
                        a_gnt_q    <= !pick_b;
                        b_gnt_q    <= pick_b;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    we_q <= 4'b0000;
                    if (lat_we) begin
                        a_ack_q <= !sel;
                        b_ack_q <= sel;
                        state   <= DONE;
                    end else begin
                        cnt   <= 2'(RD_LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        if (sel) b_rdata_q <= rd_rot;
                        else     a_rdata_q <= rd_rot;
                        a_ack_q <= !sel;
                        b_ack_q <= sel;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_gnt      = a_gnt_q;
    assign bus.b_gnt      = b_gnt_q;
    assign bus.a_ack      = a_ack_q;
    assign bus.b_ack      = b_ack_q;
    assign bus.a_rdata    = a_rdata_q;
    assign bus.b_rdata    = b_rdata_q;
    assign bus.ram_addr0  = addr_q[0];
    assign bus.ram_addr1  = addr_q[1];
    assign bus.ram_addr2  = addr_q[2];
    assign bus.ram_addr3  = addr_q[3];
    assign bus.ram_wdata0 = wdata_q[0];
    assign bus.ram_wdata1 = wdata_q[1];
    assign bus.ram_wdata2 = wdata_q[2];
    assign bus.ram_wdata3 = wdata_q[3];
    assign bus.ram_we     = we_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_ram_bank_access_ctrl.sv
// Drives RD_LATENCY=1 and RD_LATENCY=3 controllers with identical requests against bank RAM models.
// Expected values come from a flat byte-addressed reference memory and byte-address arithmetic.
module tb_ram_bank_access_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_bank_access_ctrl_if #(.BYTE_ADDR_W(18)) i1 ();
    ram_bank_access_ctrl_if #(.BYTE_ADDR_W(18)) i3 ();

    logic        a_req, a_we, b_req, b_we;
    logic [1:0]  a_size, b_size;
    logic [17:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    assign i1.a_req = a_req;   assign i3.a_req = a_req;
    assign i1.a_we = a_we;     assign i3.a_we = a_we;
    assign i1.a_size = a_size; assign i3.a_size = a_size;
    assign i1.a_addr = a_addr; assign i3.a_addr = a_addr;
    assign i1.a_wdata = a_wdata; assign i3.a_wdata = a_wdata;
    assign i1.b_req = b_req;   assign i3.b_req = b_req;
    assign i1.b_we = b_we;     assign i3.b_we = b_we;
    assign i1.b_size = b_size; assign i3.b_size = b_size;
    assign i1.b_addr = b_addr; assign i3.b_addr = b_addr;
    assign i1.b_wdata = b_wdata; assign i3.b_wdata = b_wdata;

    ram_bank_access_ctrl #(.BYTE_ADDR_W(18), .RD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    ram_bank_access_ctrl #(.BYTE_ADDR_W(18), .RD_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3));

    // Observation arrays: first index 0 = latency-1 DUT, 1 = latency-3 DUT; port 0 = A, 1 = B.
    logic        gnt_o [2][2];
    logic        ack_o [2][2];
    logic [31:0] rd_o  [2][2];
    logic        busy_o [2];
    logic [15:0] ba [2][4];
    logic [7:0]  bw [2][4];
    logic [3:0]  bwe [2];

    assign gnt_o[0][0] = i1.a_gnt;  assign gnt_o[0][1] = i1.b_gnt;
    assign gnt_o[1][0] = i3.a_gnt;  assign gnt_o[1][1] = i3.b_gnt;
    assign ack_o[0][0] = i1.a_ack;  assign ack_o[0][1] = i1.b_ack;
    assign ack_o[1][0] = i3.a_ack;  assign ack_o[1][1] = i3.b_ack;
    assign rd_o[0][0] = i1.a_rdata; assign rd_o[0][1] = i1.b_rdata;
    assign rd_o[1][0] = i3.a_rdata; assign rd_o[1][1] = i3.b_rdata;
    assign busy_o[0] = i1.busy;     assign busy_o[1] = i3.busy;
    assign bwe[0] = i1.ram_we;      assign bwe[1] = i3.ram_we;
    assign ba[0][0] = i1.ram_addr0; assign ba[0][1] = i1.ram_addr1;
    assign ba[0][2] = i1.ram_addr2; assign ba[0][3] = i1.ram_addr3;
    assign ba[1][0] = i3.ram_addr0; assign ba[1][1] = i3.ram_addr1;
    assign ba[1][2] = i3.ram_addr2; assign ba[1][3] = i3.ram_addr3;
    assign bw[0][0] = i1.ram_wdata0; assign bw[0][1] = i1.ram_wdata1;
    assign bw[0][2] = i1.ram_wdata2; assign bw[0][3] = i1.ram_wdata3;
    assign bw[1][0] = i3.ram_wdata0; assign bw[1][1] = i3.ram_wdata1;
    assign bw[1][2] = i3.ram_wdata2; assign bw[1][3] = i3.ram_wdata3;

    // Bank RAMs: read data leaves a pipeline whose depth equals the DUT's RD_LATENCY.
    logic [7:0] bank_mem [2][4][65536];
    logic [7:0] pipe [2][4][3];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 4; b++) begin
                if (bwe[d][b]) bank_mem[d][b][ba[d][b]] <= bw[d][b];
                pipe[d][b][0] <= bank_mem[d][b][ba[d][b]];
                pipe[d][b][1] <= pipe[d][b][0];
                pipe[d][b][2] <= pipe[d][b][1];
            end
        end
    end
    assign i1.ram_rdata0 = pipe[0][0][0]; assign i1.ram_rdata1 = pipe[0][1][0];
    assign i1.ram_rdata2 = pipe[0][2][0]; assign i1.ram_rdata3 = pipe[0][3][0];
    assign i3.ram_rdata0 = pipe[1][0][2]; assign i3.ram_rdata1 = pipe[1][1][2];
    assign i3.ram_rdata2 = pipe[1][2][2]; assign i3.ram_rdata3 = pipe[1][3][2];

    logic [7:0]  ref_mem [262144];
    logic [31:0] exp_rd [2];
    int          last_port;
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bank b serves the first byte address at or after a that is congruent to b mod 4.
    function automatic logic [15:0] exp_bank_addr(input logic [17:0] a, input int b);
        int t;
        t = (int'(a) + ((b - int'(a[1:0])) & 3)) % 262144;
        return 16'(t >> 2);
    endfunction

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("%s d%0d gnt%0d", tag, d, p), 32'(gnt_o[d][p]), 32'd0);
                check($sformatf("%s d%0d ack%0d", tag, d, p), 32'(ack_o[d][p]), 32'd0);
                check($sformatf("%s d%0d rdata%0d", tag, d, p), rd_o[d][p], 32'd0);
            end
            check($sformatf("%s d%0d busy", tag, d), 32'(busy_o[d]), 32'd0);
            check($sformatf("%s d%0d ram_we", tag, d), 32'(bwe[d]), 32'd0);
            for (int b = 0; b < 4; b++) begin
                check($sformatf("%s d%0d ram_addr%0d", tag, d, b), 32'(ba[d][b]), 32'd0);
                check($sformatf("%s d%0d ram_wdata%0d", tag, d, b), 32'(bw[d][b]), 32'd0);
            end
        end
    endtask

    task automatic txn(input int port, input logic we, input logic [1:0] size,
                       input logic [17:0] addr, input logic [31:0] wdata);
        int          n;
        int          cyc;
        logic [3:0]  mask;
        logic [31:0] e;
        logic [31:0] rd_at_ack [2];
        int          ack_cyc [2];
        bit          got [2];
        n    = size_bytes(size);
        mask = 4'b0000;
        for (int k = 0; k < n; k++) mask[(int'(addr) + k) % 4] = 1'b1;
        if (port == 0) begin
            a_req = 1'b1; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = 1'b1; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d gnt p%0d", d, port), 32'(gnt_o[d][port]), 32'd1);
            check($sformatf("d%0d gnt other", d), 32'(gnt_o[d][1-port]), 32'd0);
            check($sformatf("d%0d busy access", d), 32'(busy_o[d]), 32'd1);
            check($sformatf("d%0d ram_we @%h", d, addr), 32'(bwe[d]), we ? 32'(mask) : 32'd0);
            for (int b = 0; b < 4; b++)
                check($sformatf("d%0d ram_addr%0d @%h", d, b, addr), 32'(ba[d][b]), 32'(exp_bank_addr(addr, b)));
            if (we)
                for (int k = 0; k < n; k++)
                    check($sformatf("d%0d wdata byte%0d @%h", d, k, addr),
                          32'(bw[d][(int'(addr) + k) % 4]), 32'(wdata[8*k +: 8]));
        end
        a_req = 1'b0;
        b_req = 1'b0;
        got = '{0, 0};
        ack_cyc = '{0, 0};
        rd_at_ack = '{0, 0};
        cyc = 1;
        while (!(got[0] && got[1]) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d ram_we idle", d), 32'(bwe[d]), 32'd0);
                check($sformatf("d%0d ack other", d), 32'(ack_o[d][1-port]), 32'd0);
                if (ack_o[d][port] && !got[d]) begin
                    got[d] = 1'b1;
                    ack_cyc[d] = cyc;
                    rd_at_ack[d] = rd_o[d][port];
                end
            end
        end
        if (!we) begin
            for (int k = 0; k < 4; k++) e[8*k +: 8] = ref_mem[(int'(addr) + k) % 262144];
            exp_rd[port] = e;
        end else begin
            for (int k = 0; k < n; k++) ref_mem[(int'(addr) + k) % 262144] = wdata[8*k +: 8];
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d ack seen", d), 32'(got[d]), 32'd1);
            check($sformatf("d%0d ack cycle", d), 32'(ack_cyc[d]), we ? 32'd2 : (d == 0 ? 32'd3 : 32'd5));
            if (!we) check($sformatf("d%0d rdata p%0d @%h", d, port, addr), rd_at_ack[d], exp_rd[port]);
            check($sformatf("d%0d rdata other p%0d", d, 1 - port), rd_o[d][1-port], exp_rd[1-port]);
        end
        last_port = port;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check($sformatf("d%0d busy idle", d), 32'(busy_o[d]), 32'd0);
    endtask

    task automatic arb();
        int first;
        int g [2];
        int lastg [2];
        first = 1 - last_port;
        g = '{0, 0};
        lastg = '{-1, -1};
        a_req = 1'b1; a_we = 1'b1; a_size = 2'd2; a_addr = 18'h20; a_wdata = 32'h11223344;
        b_req = 1'b1; b_we = 1'b1; b_size = 2'd2; b_addr = 18'h28; b_wdata = 32'h55667788;
        repeat (12) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d gnt exclusive", d), 32'(gnt_o[d][0] & gnt_o[d][1]), 32'd0);
                check($sformatf("d%0d ack exclusive", d), 32'(ack_o[d][0] & ack_o[d][1]), 32'd0);
                if (gnt_o[d][0] || gnt_o[d][1]) begin
                    check($sformatf("d%0d arb order g%0d", d, g[d]), 32'(gnt_o[d][1]), 32'(first ^ (g[d] & 1)));
                    lastg[d] = gnt_o[d][1] ? 1 : 0;
                    g[d]++;
                end
                for (int p = 0; p < 2; p++)
                    if (ack_o[d][p]) check($sformatf("d%0d ack to granted", d), 32'(p), 32'(lastg[d]));
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        for (int d = 0; d < 2; d++) check($sformatf("d%0d arb grant count", d), 32'(g[d]), 32'd4);
        for (int k = 0; k < 4; k++) begin
            ref_mem[32'h20 + k] = a_wdata[8*k +: 8];
            ref_mem[32'h28 + k] = b_wdata[8*k +: 8];
        end
        last_port = first ^ 1;
        @(negedge clk);
    endtask

    task automatic reset_mid_read();
        a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_addr = 18'h10;
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check($sformatf("d%0d busy in wait", d), 32'(busy_o[d]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid-read reset");
        exp_rd = '{0, 0};
        last_port = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d no ack after reset", d), 32'(ack_o[d][0] | ack_o[d][1]), 32'd0);
                check($sformatf("d%0d idle after reset", d), 32'(busy_o[d]), 32'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        last_port = 1;
        exp_rd = '{0, 0};
        a_req = 1'b0; a_we = 1'b0; a_size = 2'd0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_size = 2'd0; b_addr = '0; b_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 16; w++) begin
            txn(w & 1, 1'b1, 2'd2, 18'(w * 4), $urandom);
            txn(w & 1, 1'b1, 2'd2, 18'h3FFC0 + 18'(w * 4), $urandom);
        end

        txn(0, 1'b1, 2'd2, 18'h00010, 32'hDDCCBBAA);
        txn(0, 1'b0, 2'd2, 18'h00010, 32'h0);
        txn(0, 1'b1, 2'd2, 18'h00013, 32'h87654321);
        txn(0, 1'b0, 2'd2, 18'h00013, 32'h0);
        txn(0, 1'b1, 2'd1, 18'h00006, 32'h0000BEEF);
        txn(0, 1'b1, 2'd0, 18'h00007, 32'h0000005A);
        txn(0, 1'b0, 2'd2, 18'h00004, 32'h0);
        txn(0, 1'b1, 2'd3, 18'h3FFFE, 32'hCAFEF00D);
        txn(0, 1'b0, 2'd2, 18'h3FFFE, 32'h0);
        txn(1, 1'b0, 2'd2, 18'h00013, 32'h0);
        txn(0, 1'b0, 2'd2, 18'h00004, 32'h0);
        txn(0, 1'b0, 2'd1, 18'h3FFFF, 32'h0);

        arb();
        reset_mid_read();
        arb();

        for (int i = 0; i < 60; i++) begin
            logic [17:0] ra;
            ra = ($urandom_range(0, 1) == 1) ? 18'h3FFC0 + 18'($urandom_range(0, 63))
                                             : 18'($urandom_range(0, 60));
            txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_bank_access_ctrl.md
Name: ram_bank_access_ctrl

Overview:
- Sequences and shares the composed 32-bit RAM (four 8-bit banks, 16-bit word address per bank, 18-bit byte address) between two requesters: port A (core) and port B (loader/DMA).
- Round-robin arbitration; one access in flight.
- Computes per-bank addresses for unaligned accesses, drives byte write strobes, and rotates read data back into little-endian order.
- Sits between the requesters and the four bank RAM instances.

Parameters:
- BYTE_ADDR_W, 18, byte address width. Word address is BYTE_ADDR_W-2 = 16 bits.
- RD_LATENCY, 1, cycles from bank address/strobe sample to bank read data valid. Legal range 1..4.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  port A request; hold with a_we/a_size/a_addr/a_wdata stable until a_gnt
- a_we  in  1  1=write, 0=read
- a_size  in  2  0=byte, 1=half, 2=word, 3=treated as word
- a_addr  in  18  byte address, any alignment
- a_wdata  in  32  write data, byte k at a_addr+k
- a_gnt  out  1  one-cycle pulse: request accepted and latched
- a_ack  out  1  one-cycle pulse: access complete
- a_rdata  out  32  read data, valid from a_ack; holds until the next port-A read completes
- b_req, b_we, b_size, b_addr, b_wdata, b_gnt, b_ack, b_rdata: same as port A, for port B
- ram_addr0..ram_addr3  out  16 each  per-bank word address
- ram_wdata0..ram_wdata3  out  8 each  per-bank write byte
- ram_we  out  4  per-bank write enable
- ram_rdata0..ram_rdata3  in  8 each  per-bank read byte
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0), all of the following take effect immediately:
  - FSM goes to IDLE; any in-flight access is dropped with no ack.
  - All outputs are 0, including rdata registers, ram_addr*, ram_wdata* and ram_we.
  - last_grant is set to B, so port A wins the first tie.
- Address split:
  - word = addr[17:2], off = addr[1:0].
  - Bank b address = word + (b < off ? 1 : 0), modulo 2^16. Bank 3 always gets word.
  - Data byte k maps to bank (off+k) mod 4.
  - Wrap-around: word=0xFFFF with off≠0 sends the incremented banks to 0x0000.
- Write strobes: n = 1/2/4 bytes for size 0/1/2-3. ram_we[(off+k) mod 4] = 1 for k < n; all other bank strobes are 0.
- Read data: rdata byte k = ram_rdata of bank (off+k) mod 4. All 4 bytes are always returned; the requester masks by size.
- FSM states: IDLE, ACCESS, WAIT, DONE.
  - IDLE:
    - If only one port requests, grant that port.
    - If both request, grant the port that is not last_grant.
    - On grant: latch we/size/addr/wdata and port id, update last_grant, pulse x_gnt in the next cycle, go to ACCESS.
  - ACCESS (1 cycle): ram_addr*, ram_wdata* and ram_we are driven from the latched request. ram_we is nonzero only for writes. Writes go to DONE; reads load the counter with RD_LATENCY-1 and go to WAIT.
  - WAIT: ram_we=0 and addresses are held. When the counter reaches 0, capture the rotated ram_rdata into the granted port's rdata and go to DONE; otherwise decrement.
  - DONE (1 cycle): pulse x_ack for the granted port, then go to IDLE.
- Latency, with req seen in IDLE at cycle 0:
  - x_gnt at cycle 1 (ACCESS).
  - Write: ack at cycle 2.
  - Read: ack at cycle 2+RD_LATENCY, i.e. cycle 3 at the default.
  - Throughput: one access per 3 cycles (writes) or 3+RD_LATENCY cycles (reads).
- Requests that arrive outside IDLE are ignored until IDLE; requesters hold req. A req dropped before gnt is never served.
- ram_addr* hold their last value in IDLE/DONE. ram_we is 0 in every state except ACCESS-with-write.
- gnt and ack never assert for both ports in the same cycle. ack only goes to the port last granted.
- The non-granted port's rdata never changes.

Test Plan:
- Aligned word write/read: A writes 0xDDCCBBAA at 0x00010 (word 4, off 0) -> ACCESS ram_addr0..3=4, ram_we=4'b1111, ram_wdata0..3=AA,BB,CC,DD. a_ack at cycle 2. A read at 0x00010 returns a_rdata=0xDDCCBBAA at cycle 3.
- Unaligned word off=3 at 0x00013: ram_addr0..2=5, ram_addr3=4, ram_wdata3=byte0, ram_wdata0=byte1, ram_wdata1=byte2, ram_wdata2=byte3. A later read at 0x00013 returns the original word.
- Sub-word strobes: half write at 0x00006 (off 2) -> ram_we=4'b1100, ram_addr2/3=1. Byte write at 0x00007 -> ram_we=4'b1000. Bank data outside the strobes is unchanged on readback.
- Wrap: word write at 0x3FFFE (word 0xFFFF, off 2) -> ram_addr0/1=0x0000, ram_addr2/3=0xFFFF.
- Arbitration: a_req and b_req held high together -> grants A, B, A, B alternating. gnt and ack never both ports in one cycle. b_rdata is unchanged during A's reads.
- Reset mid-read: rst_n=0 during WAIT -> immediate IDLE, all outputs 0, no ack. After release, the first simultaneous request is granted to A. Repeat the read tests with RD_LATENCY=3: ack at cycle 5.
